// File: rtl/cell_pos_streamer_pkg.sv
// Shared widths, FSM encoding and skid-FIFO payload for the cell position streamer.
package cell_pos_streamer_pkg;

  localparam int unsigned POS_DATA_WIDTH  = 96;
  localparam int unsigned CELL_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CNT,
    ST_WAIT_CNT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [POS_DATA_WIDTH-1:0]  pos;
    logic [CELL_ADDR_WIDTH-1:0] pid;
    logic                       last;
  } fifo_entry_t;

  // Clamp a raw count word to the highest valid particle address.
  function automatic logic [CELL_ADDR_WIDTH-1:0] sat_count(
    input logic [CELL_ADDR_WIDTH-1:0] raw,
    input logic [CELL_ADDR_WIDTH-1:0] max_cnt
  );
    return (raw > max_cnt) ? max_cnt : raw;
  endfunction

endpackage

// File: rtl/cell_pos_streamer_if.sv
// Cell RAM port plus particle output stream, as seen from the streamer (master) and its neighbours (slave).
interface cell_pos_streamer_if
  import cell_pos_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = POS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CELL_ADDR_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pos;
  logic [ADDR_WIDTH-1:0] out_pid;
  logic                  out_last;

  modport master (
    output mem_address, mem_rden, mem_wren, mem_data,
    input  mem_q,
    output out_valid, out_pos, out_pid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_rden, mem_wren, mem_data,
    output mem_q,
    input  out_valid, out_pos, out_pid, out_last,
    output out_ready
  );

endinterface

// File: rtl/cell_pos_streamer_pos_skid_fifo.sv
// Shift-register skid FIFO; the head entry is always entry 0, so dout/valid come straight from flops.
module pos_skid_fifo
  import cell_pos_streamer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fifo_entry_t   din,
  input  logic          pop,
  output fifo_entry_t   dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int unsigned IW = $clog2(DEPTH);

  fifo_entry_t   ent [DEPTH];
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] wr_pos;

  // A simultaneous pop shifts everything down, so the write slot moves with it.
  assign wr_pos    = count - CW'(pop);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign dout      = ent[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) ent[i] <= ent[i+1];
      end
      if (push) ent[IW'(wr_pos)] <= din;
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/cell_pos_streamer.sv
// Streams one cell's particle positions: reads the count at address 0, then addresses 1..N,
// hiding the RAM's 2-cycle latency behind a credit-checked skid FIFO.
module cell_pos_streamer
  import cell_pos_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = POS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = CELL_ADDR_WIDTH,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  cell_pos_streamer_if.master   bus
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                st;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;

  logic                  trk0_v, trk1_v;
  logic [ADDR_WIDTH-1:0] trk0_pid, trk1_pid;

  fifo_entry_t           fifo_din, fifo_dout;
  logic                  fifo_valid, push, pop;
  logic [CW-1:0]         fifo_count;
  logic [OCC_W-1:0]      occ;
  logic                  credit_ok, drained;
  logic [ADDR_WIDTH-1:0] cnt_sat;

  assign cnt_sat = sat_count(bus.mem_q[ADDR_WIDTH-1:0], MAX_CNT);

  // The count word (pid 0) returns through the same tracker but never enters the FIFO.
  assign push     = trk1_v && (trk1_pid != '0);
  assign pop      = fifo_valid && bus.out_ready;
  assign fifo_din = '{pos: bus.mem_q, pid: trk1_pid, last: (trk1_pid == particle_count)};

  // Entries still owed to the FIFO plus those it will still hold after this cycle's pop.
  assign occ = OCC_W'(fifo_count) - OCC_W'(pop) + OCC_W'(mem_rden)
             + OCC_W'(trk0_v) + OCC_W'(trk1_v);
  assign credit_ok = (occ < OCC_W'(FIFO_DEPTH));

  assign drained = !mem_rden && !trk0_v && !trk1_v &&
                   ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk0_v   <= 1'b0;
      trk1_v   <= 1'b0;
      trk0_pid <= '0;
      trk1_pid <= '0;
    end else begin
      trk0_v   <= mem_rden;
      trk0_pid <= mem_address;
      trk1_v   <= trk0_v;
      trk1_pid <= trk0_pid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      particle_count <= '0;
      mem_address    <= '0;
      mem_rden       <= 1'b0;
      next_addr      <= '0;
    end else begin
      mem_rden <= 1'b0;
      done     <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start) begin
            st          <= ST_RD_CNT;
            busy        <= 1'b1;
            mem_rden    <= 1'b1;
            mem_address <= '0;
          end
        end
        ST_RD_CNT: st <= ST_WAIT_CNT;
        ST_WAIT_CNT: begin
          if (trk1_v) begin
            particle_count <= cnt_sat;
            if (cnt_sat == '0) begin
              st   <= ST_DONE;
              done <= 1'b1;
            end else begin
              // First particle read goes out together with the count latch.
              mem_rden    <= 1'b1;
              mem_address <= ADDR_WIDTH'(1);
              next_addr   <= ADDR_WIDTH'(2);
              st          <= (cnt_sat == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (credit_ok) begin
            mem_rden    <= 1'b1;
            mem_address <= next_addr;
            next_addr   <= next_addr + ADDR_WIDTH'(1);
            if (next_addr == particle_count) st <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            st   <= ST_DONE;
            done <= 1'b1;
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  pos_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.mem_address = mem_address;
  assign bus.mem_rden    = mem_rden;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = DATA_WIDTH'(0);
  assign bus.out_valid   = fifo_valid;
  assign bus.out_pos     = fifo_dout.pos;
  assign bus.out_pid     = fifo_dout.pid;
  assign bus.out_last    = fifo_dout.last;

endmodule

// File: tb/tb_cell_pos_streamer.sv
// Directed bench for cell_pos_streamer: behavioural 2-cycle RAM, beat monitor and cycle-exact checks.
module tb_cell_pos_streamer;
  import cell_pos_streamer_pkg::*;

  localparam int unsigned DW = 96;
  localparam int unsigned AW = 8;
  localparam int unsigned PN = 220;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] particle_count;

  always #5 clk = ~clk;

  cell_pos_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cell_pos_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .bus(bus)
  );

  // Registered-output RAM: address captured one edge, data presented the next.
  logic [DW-1:0] ram [256];
  logic [AW-1:0] s1_a;
  always @(posedge clk) begin
    s1_a      <= bus.mem_address;
    bus.mem_q <= ram[s1_a];
  end

  typedef struct {
    logic [DW-1:0] pos;
    logic [AW-1:0] pid;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t beats[$];
  int    done_cyc[$];
  int    cyc = 0;
  int    t0 = 0;
  int    outstanding = 0, max_out = 0, stab_err = 0, bad_addr = 0;
  logic  prev_stall = 1'b0;
  logic [DW+AW:0] prev_word;
  int    checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (bus.mem_rden && bus.mem_address != '0) outstanding++;
      if (bus.mem_rden && bus.mem_address >= AW'(PN)) bad_addr++;
      if (outstanding > max_out) max_out = outstanding;
      if (prev_stall && (!bus.out_valid ||
          {bus.out_pos, bus.out_pid, bus.out_last} != prev_word)) stab_err++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_pos, bus.out_pid, bus.out_last};
      if (bus.out_valid && bus.out_ready) begin
        beats.push_back('{pos: bus.out_pos, pid: bus.out_pid, last: bus.out_last, cyc: cyc});
        outstanding--;
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pos_of(input int t, input int i);
    logic [31:0] x, y, z;
    x = 32'(32'h1000_0000 + t * 1024 + i);
    y = 32'(32'h2000_0000 + t * 1024 + i * 7);
    z = 32'(32'h3000_0000 + t * 1024 + i * 13);
    return {z, y, x};
  endfunction

  task automatic fill(input int t, input logic [DW-1:0] cnt_word);
    ram[0] = cnt_word;
    for (int i = 1; i < 256; i++) ram[i] = pos_of(t, i);
  endtask

  task automatic clear_mon();
    beats.delete();
    done_cyc.delete();
    max_out  = 0;
    stab_err = 0;
    bad_addr = 0;
  endtask

  // Called mid-cycle; the calling cycle becomes cycle 0.
  task automatic start_now();
    start = 1'b1;
    t0    = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    @(negedge clk);
    while (cyc < t0 + c) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 128'(done_cyc.size() != 0), 128'(1));
    @(negedge clk);
  endtask

  task automatic check_beats(input string tag, input int t, input int n);
    int err = 0;
    check({tag, "_beat_count"}, 128'(beats.size()), 128'(n));
    foreach (beats[i]) begin
      if (beats[i].pid !== AW'(i + 1) || beats[i].pos !== pos_of(t, i + 1) ||
          beats[i].last !== (i + 1 == n)) err++;
    end
    check({tag, "_beat_order"}, 128'(err), 128'(0));
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 128'({busy, done, particle_count, bus.mem_address, bus.mem_rden,
                             bus.out_valid, bus.out_pid, bus.out_last}), 128'(0));
    check("reset_pos", 128'(bus.out_pos), 128'(0));
    rst = 1'b0;

    // Nominal: three particles, consumer always ready.
    clear_mon();
    fill(1, DW'(3));
    @(negedge clk);
    start_now();
    wait_cycle(1);
    check("nom_rd_cnt", 128'({bus.mem_rden, bus.mem_address, busy}), 128'({1'b1, 8'h00, 1'b1}));
    check("nom_const_wr", 128'({bus.mem_wren, bus.mem_data}), 128'(0));
    wait_cycle(4);
    check("nom_first_rd", 128'({bus.mem_rden, bus.mem_address}), 128'({1'b1, 8'h01}));
    check("nom_count", 128'(particle_count), 128'(3));
    wait_done("nom", 40);
    check_beats("nom", 1, 3);
    check("nom_first_beat_cyc", 128'(beats.size() > 0 ? beats[0].cyc - t0 : -1), 128'(7));
    check("nom_last_beat_cyc", 128'(beats.size() > 2 ? beats[2].cyc - t0 : -1), 128'(9));
    check("nom_done_cyc", 128'(done_cyc.size() > 0 ? done_cyc[0] - t0 : -1), 128'(10));

    // Empty cell, then a back-to-back start under backpressure.
    clear_mon();
    fill(2, DW'(0));
    @(negedge clk);
    start_now();
    wait_cycle(4);
    check("empty_done_c4", 128'({done, busy}), 128'(2'b11));
    wait_cycle(5);
    check("empty_idle_c5", 128'({busy, done, bus.out_valid}), 128'(0));
    check("empty_no_beats", 128'(beats.size()), 128'(0));
    check("empty_count", 128'(particle_count), 128'(0));
    clear_mon();
    fill(3, DW'(8));
    start_now();
    wait_cycle(1);
    check("b2b_rd_cnt", 128'({bus.mem_rden, bus.mem_address, busy}), 128'({1'b1, 8'h00, 1'b1}));
    for (int k = 0; k < 200 && done_cyc.size() == 0; k++) begin
      @(posedge clk);
      #1 bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    check("bp_done_seen", 128'(done_cyc.size()), 128'(1));
    check_beats("bp", 3, 8);
    check("bp_stall_stable", 128'(stab_err), 128'(0));
    check("bp_credit", 128'(max_out <= int'(FD)), 128'(1));

    // Saturated count: 0xFF clamps to PARTICLE_NUM-1.
    clear_mon();
    fill(4, {88'hA5A5_0000_1234_5678_9ABC_DE, 8'hFF});
    @(negedge clk);
    start_now();
    wait_done("sat", 400);
    check("sat_count", 128'(particle_count), 128'(219));
    check_beats("sat", 4, 219);
    check("sat_last_pid", 128'(beats.size() > 0 ? beats[beats.size()-1].pid : '0), 128'(219));
    check("sat_no_oob_read", 128'(bad_addr), 128'(0));
    check("sat_done_cyc", 128'(done_cyc.size() > 0 ? done_cyc[0] - t0 : -1), 128'(226));
    check("sat_credit", 128'(max_out <= int'(FD)), 128'(1));

    // Asynchronous reset in the middle of a 5-particle stream, then a clean restart.
    clear_mon();
    fill(5, DW'(5));
    @(negedge clk);
    start_now();
    wait_cycle(9);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outs", 128'({busy, done, particle_count, bus.mem_address, bus.mem_rden,
                                 bus.out_valid, bus.out_pid, bus.out_last}), 128'(0));
    check("rst_async_pos", 128'(bus.out_pos), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    @(negedge clk);
    start_now();
    wait_done("rst", 60);
    check_beats("rst", 5, 5);

    // Second start during STREAM must be ignored.
    clear_mon();
    fill(6, DW'(4));
    @(negedge clk);
    start_now();
    wait_cycle(5);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("sbusy", 60);
    repeat (15) @(negedge clk);
    check("sbusy_one_done", 128'(done_cyc.size()), 128'(1));
    check_beats("sbusy", 6, 4);
    check("sbusy_done_cyc", 128'(done_cyc.size() > 0 ? done_cyc[0] - t0 : -1), 128'(11));
    check("sbusy_idle", 128'({busy, bus.out_valid}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
